// File: rtl/cpu_ctl_pkg.sv
// Shared encodings, FSM state type and control-bundle layout for the
// decode-stage control sequencer.
package cpu_ctl_pkg;

    localparam logic [3:0] OP_HALT  = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_BGT   = 4'b0100;
    localparam logic [3:0] OP_BLT   = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_JUMP  = 4'b0111;
    localparam logic [3:0] OP_LW    = 4'b1010;
    localparam logic [3:0] OP_SW    = 4'b1011;
    localparam logic [3:0] OP_LB    = 4'b1100;
    localparam logic [3:0] OP_SB    = 4'b1101;
    localparam logic [3:0] OP_TYPEA = 4'b1111;

    localparam logic [1:0] MD_ALU = 2'b00;
    localparam logic [1:0] MD_MUL = 2'b01;
    localparam logic [1:0] MD_DIV = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;

    localparam logic [1:0] RW_NONE = 2'b00;
    localparam logic [1:0] RW_RD   = 2'b01;
    localparam logic [1:0] RW_HILO = 2'b10;

    localparam logic [2:0] JB_NONE = 3'b000;
    localparam logic [2:0] JB_BLT  = 3'b001;
    localparam logic [2:0] JB_BGT  = 3'b010;
    localparam logic [2:0] JB_BEQ  = 3'b011;
    localparam logic [2:0] JB_JUMP = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_MD_BUSY = 2'b01,
        ST_MD_WB   = 2'b10,
        ST_HALTED  = 2'b11
    } ctlState_t;

    typedef struct packed {
        logic       aluBType;
        logic       aluSrc;
        logic       zeroExtendFlag;
        logic       memRead;
        logic       memToReg;
        logic       memWrite;
        logic       storeByte;
        logic [1:0] aluControlOp;
        logic [1:0] regWrite;
        logic [2:0] jumpBranch;
    } ctlBundle_t;

    localparam ctlBundle_t BUNDLE_NONE = '{
        aluBType: 1'b0, aluSrc: 1'b0, zeroExtendFlag: 1'b0, memRead: 1'b0,
        memToReg: 1'b0, memWrite: 1'b0, storeByte: 1'b0,
        aluControlOp: ALU_ADD, regWrite: RW_NONE, jumpBranch: JB_NONE
    };

endpackage

// File: rtl/control_decode.sv
// Combinational opcode/multiDiv decoder: produces the control bundle plus
// halt, multi-cycle and illegal classification flags.
module control_decode
    import cpu_ctl_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [1:0]          multiDiv,
    output ctlBundle_t          bundle,
    output logic                illegal,
    output logic                isHalt,
    output logic                isMultiDiv,
    output logic                mdOp
);

    logic highBits;

    // Any opcode bit above the 4-bit base field marks the instruction illegal.
    assign highBits = (opcode >> 3'd4) != {OPCODE_W{1'b0}};

    // Opcode map lookup; unlisted encodings fall through to illegal.
    always_comb begin
        bundle     = BUNDLE_NONE;
        illegal    = 1'b0;
        isHalt     = 1'b0;
        isMultiDiv = 1'b0;
        mdOp       = 1'b0;
        if (highBits) begin
            illegal = 1'b1;
        end else begin
            case (opcode[3:0])
                OP_TYPEA: begin
                    case (multiDiv)
                        MD_ALU: begin
                            bundle.aluBType     = 1'b1;
                            bundle.aluControlOp = ALU_FUNCT;
                            bundle.regWrite     = RW_RD;
                        end
                        MD_MUL: isMultiDiv = 1'b1;
                        MD_DIV: begin
                            isMultiDiv = 1'b1;
                            mdOp       = 1'b1;
                        end
                        default: illegal = 1'b1;
                    endcase
                end
                OP_ADDI: begin
                    bundle.aluSrc   = 1'b1;
                    bundle.regWrite = RW_RD;
                end
                OP_ORI: begin
                    bundle.aluSrc         = 1'b1;
                    bundle.zeroExtendFlag = 1'b1;
                    bundle.aluControlOp   = ALU_OR;
                    bundle.regWrite       = RW_RD;
                end
                OP_LW, OP_LB: begin
                    bundle.memRead  = 1'b1;
                    bundle.memToReg = 1'b1;
                    bundle.aluSrc   = 1'b1;
                    bundle.regWrite = RW_RD;
                end
                OP_SW: begin
                    bundle.memWrite = 1'b1;
                    bundle.aluSrc   = 1'b1;
                end
                OP_SB: begin
                    bundle.memWrite  = 1'b1;
                    bundle.storeByte = 1'b1;
                    bundle.aluSrc    = 1'b1;
                end
                OP_BLT: begin
                    bundle.aluControlOp = ALU_SUB;
                    bundle.jumpBranch   = JB_BLT;
                end
                OP_BGT: begin
                    bundle.aluControlOp = ALU_SUB;
                    bundle.jumpBranch   = JB_BGT;
                end
                OP_BEQ: begin
                    bundle.aluControlOp = ALU_SUB;
                    bundle.jumpBranch   = JB_BEQ;
                end
                OP_JUMP: bundle.jumpBranch = JB_JUMP;
                OP_HALT: isHalt = 1'b1;
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Decode-stage control sequencer: registers the decoded bundle, sequences
// multiply/divide with fetch stall, honours branch flushes and sticky halt.
module control_sequencer
    import cpu_ctl_pkg::*;
#(
    parameter int OPCODE_W   = 4,
    parameter int MD_LATENCY = 16
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                instrValid,
    output logic                instrReady,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [1:0]          multiDiv,
    input  logic                branchFlush,
    output logic                ctlValid,
    output logic                aluBType,
    output logic                aluSrc,
    output logic                zeroExtendFlag,
    output logic                memRead,
    output logic                memToReg,
    output logic                memWrite,
    output logic                storeByte,
    output logic [1:0]          aluControlOp,
    output logic [1:0]          regWrite,
    output logic [2:0]          jumpBranch,
    output logic                mdStart,
    output logic                mdOp,
    output logic                stall,
    output logic                halted,
    output logic                illegalOp
);

    localparam int                CNT_W    = $clog2(MD_LATENCY);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MD_LATENCY - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    ctlState_t        stateR, stateNext;
    logic [CNT_W-1:0] cntR, cntNext;
    ctlBundle_t       bundleR, bundleNext, decBundle;
    logic             ctlValidR, ctlValidNext;
    logic             mdStartR, mdStartNext;
    logic             mdOpR, mdOpNext;
    logic             stallR, stallNext;
    logic             haltedR, haltedNext;
    logic             illegalR, illegalNext;
    logic             decIllegal, decHalt, decMultiDiv, decMdOp;
    logic             accept;

    control_decode #(.OPCODE_W(OPCODE_W)) uDecode (
        .opcode     (opcode),
        .multiDiv   (multiDiv),
        .bundle     (decBundle),
        .illegal    (decIllegal),
        .isHalt     (decHalt),
        .isMultiDiv (decMultiDiv),
        .mdOp       (decMdOp)
    );

    assign instrReady = !stallR && !haltedR;
    assign accept     = instrValid && instrReady;

    // Next-state and next-output logic; a flushed accept leaves no trace.
    always_comb begin
        stateNext    = stateR;
        cntNext      = cntR;
        bundleNext   = BUNDLE_NONE;
        ctlValidNext = 1'b0;
        mdStartNext  = 1'b0;
        mdOpNext     = mdOpR;
        stallNext    = 1'b0;
        haltedNext   = haltedR;
        illegalNext  = illegalR;
        case (stateR)
            ST_IDLE: begin
                if (accept && !branchFlush) begin
                    if (decIllegal) begin
                        stateNext   = ST_HALTED;
                        haltedNext  = 1'b1;
                        illegalNext = 1'b1;
                    end else if (decHalt) begin
                        stateNext    = ST_HALTED;
                        ctlValidNext = 1'b1;
                    end else if (decMultiDiv) begin
                        stateNext   = ST_MD_BUSY;
                        cntNext     = CNT_LOAD;
                        mdStartNext = 1'b1;
                        mdOpNext    = decMdOp;
                        stallNext   = 1'b1;
                    end else begin
                        ctlValidNext = 1'b1;
                        bundleNext   = decBundle;
                    end
                end else begin
                    stateNext = ST_IDLE;
                end
            end
            ST_MD_BUSY: begin
                stallNext = 1'b1;
                if (cntR == CNT_ZERO) begin
                    stateNext           = ST_MD_WB;
                    ctlValidNext        = 1'b1;
                    bundleNext.regWrite = RW_HILO;
                end else begin
                    cntNext = cntR - CNT_ONE;
                end
            end
            ST_MD_WB: begin
                stateNext = ST_IDLE;
                mdOpNext  = 1'b0;
            end
            ST_HALTED: begin
                // halted follows the halt pulse by one cycle
                haltedNext = 1'b1;
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stateR    <= ST_IDLE;
            cntR      <= CNT_ZERO;
            bundleR   <= BUNDLE_NONE;
            ctlValidR <= 1'b0;
            mdStartR  <= 1'b0;
            mdOpR     <= 1'b0;
            stallR    <= 1'b0;
            haltedR   <= 1'b0;
            illegalR  <= 1'b0;
        end else begin
            stateR    <= stateNext;
            cntR      <= cntNext;
            bundleR   <= bundleNext;
            ctlValidR <= ctlValidNext;
            mdStartR  <= mdStartNext;
            mdOpR     <= mdOpNext;
            stallR    <= stallNext;
            haltedR   <= haltedNext;
            illegalR  <= illegalNext;
        end
    end

    assign ctlValid       = ctlValidR;
    assign aluBType       = bundleR.aluBType;
    assign aluSrc         = bundleR.aluSrc;
    assign zeroExtendFlag = bundleR.zeroExtendFlag;
    assign memRead        = bundleR.memRead;
    assign memToReg       = bundleR.memToReg;
    assign memWrite       = bundleR.memWrite;
    assign storeByte      = bundleR.storeByte;
    assign aluControlOp   = bundleR.aluControlOp;
    assign regWrite       = bundleR.regWrite;
    assign jumpBranch     = bundleR.jumpBranch;
    assign mdStart        = mdStartR;
    assign mdOp           = mdOpR;
    assign stall          = stallR;
    assign halted         = haltedR;
    assign illegalOp      = illegalR;

endmodule
